leitor_matricula: RTL and testbench
===================================

LEITOR_MATRICULA -- requirements
Module: leitor_matricula

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000, meaning the maximum clock cycles allowed between consecutive characters of one entry.
REQ-002 SHALL have port CLK  input  1  system clock, all state updates on the rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port Char  input  4  character code: 0x0-0x9 digit, 0xA-0xE letter, 0xF illegal.
REQ-005 SHALL have port CharVal  input  1  one-cycle strobe qualifying Char.
REQ-006 SHALL have port Clear  input  1  synchronous abort of the entry in progress.
REQ-007 SHALL have port Matricula  output  24  last accepted plate, first character in [23:20], sixth in [3:0].
REQ-008 SHALL have port MatrVal  output  1  high while Matricula holds a plate accepted by the most recent entry.
REQ-009 SHALL have port Erro  output  1  high after a rejected or timed-out entry.
REQ-010 SHALL have port Count  output  3  number of characters collected in the current entry (0-6).

Function
REQ-011 SHALL implement FSM states IDLE, COLLECT, CHECK, DONE, ERR.
REQ-012 SHALL, in IDLE/DONE/ERR on CharVal=1 with Char!=0xF, load Char into shift register bits [23:20], set Count=1, clear MatrVal and Erro, and enter COLLECT.
REQ-013 SHALL, in COLLECT on CharVal=1 with Char!=0xF, place Char at nibble position Count (MSB-first) and increment Count; on the sixth character enter CHECK.
REQ-014 SHALL, on CharVal=1 with Char=0xF in any state except CHECK, enter ERR, set Erro=1, MatrVal=0, and leave Matricula unchanged.
REQ-015 SHALL ignore CharVal while in CHECK.
REQ-016 SHALL, in CHECK (exactly one cycle), form pairs P1=[23:16], P2=[15:8], P3=[7:0]; a pair is digit-pair if both nibbles <=9, letter-pair if both in 0xA-0xE, otherwise mixed.
REQ-017 SHALL accept the plate iff no pair is mixed and the number of letter-pairs is 1 or 2 (formats AA-00-00, 00-AA-00, 00-00-AA, AA-00-AA, 00-AA-AA, AA-AA-00).
REQ-018 SHALL, on accept, update Matricula and assert MatrVal=1 on the same clock edge that leaves CHECK for DONE, so downstream sees a stable MatrVal whenever Matricula changes.
REQ-019 SHALL, on reject, leave CHECK for ERR with Erro=1, MatrVal=0, Matricula unchanged.
REQ-020 SHALL hold MatrVal, Erro and Matricula constant in DONE and ERR until a new entry starts (REQ-012) or reset.
REQ-021 SHALL run a timeout counter in COLLECT, cleared on each accepted character; when it reaches TIMEOUT cycles with no CharVal, enter ERR with Erro=1.
REQ-022 SHALL, on Clear=1 in COLLECT or CHECK, return to IDLE, set Count=0, discard the partial entry, and leave Matricula/MatrVal/Erro unchanged.
REQ-023 SHALL give Clear priority over CharVal in the same cycle, and CharVal priority over timeout expiry in the same cycle.
REQ-024 SHALL reset Count to 0 on entering IDLE, DONE or ERR.

Reset
REQ-025 SHALL, on RST_N=0 at any time including mid-entry, asynchronously force state IDLE, Matricula=0, MatrVal=0, Erro=0, Count=0, timeout counter=0, shift register=0.
REQ-026 SHALL resume normal operation on the first rising CLK edge after RST_N returns high.

Verification
REQ-027 SHALL cover: chars A,B,1,2,3,4 -> one cycle after 6th strobe Matricula=0xAB1234, MatrVal=1, Erro=0, Count=0.
REQ-028 SHALL cover: chars 1,2,3,4,5,6 (no letter pair) -> Erro=1, MatrVal=0, Matricula retains previous 0xAB1234.
REQ-029 SHALL cover: chars A,1,... (mixed pair A1) -> reject at CHECK, Erro=1; Char=0xF as 3rd char -> ERR immediately next edge, Count=0.
REQ-030 SHALL cover: 3 chars then idle TIMEOUT cycles -> Erro=1; with TIMEOUT=8, CharVal on cycle 8 coincident with expiry -> character accepted, no error.
REQ-031 SHALL cover: Clear and CharVal asserted together at Count=4 -> IDLE, Count=0, outputs unchanged; then a new valid 6-char entry is accepted.
REQ-032 SHALL cover: RST_N pulsed low between clock edges at Count=5 -> all outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/leitor_matricula.sv
// Licence-plate entry reader: collects six 4-bit characters, validates the
// pair pattern (two-digit/two-letter groups) and publishes accepted plates.
module leitor_matricula #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  Char,
    input  logic        CharVal,
    input  logic        Clear,
    output logic [23:0] Matricula,
    output logic        MatrVal,
    output logic        Erro,
    output logic [2:0]  Count
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        CHECK   = 3'd2,
        DONE    = 3'd3,
        ERR     = 3'd4
    } state_t;

    localparam logic [1:0] K_DIGIT  = 2'd0;
    localparam logic [1:0] K_LETTER = 2'd1;
    localparam logic [1:0] K_MIXED  = 2'd2;

    state_t          state, state_nxt;
    logic [23:0]     shreg, shreg_nxt;
    logic [23:0]     matr_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic [2:0]      count_nxt;
    logic            matrval_nxt, erro_nxt;
    logic            char_ok, char_bad, expired, plate_ok;
    logic [1:0]      k1, k2, k3;
    logic [1:0]      n_letters;

    function automatic logic [1:0] pair_kind(input logic [7:0] p);
        logic d_hi, d_lo, l_hi, l_lo;
        d_hi = (p[7:4] <= 4'h9);
        d_lo = (p[3:0] <= 4'h9);
        l_hi = (p[7:4] >= 4'hA) && (p[7:4] <= 4'hE);
        l_lo = (p[3:0] >= 4'hA) && (p[3:0] <= 4'hE);
        if (d_hi && d_lo)      return K_DIGIT;
        else if (l_hi && l_lo) return K_LETTER;
        else                   return K_MIXED;
    endfunction

    assign char_ok  = CharVal && (Char != 4'hF);
    assign char_bad = CharVal && (Char == 4'hF);
    assign expired  = (timer == TLAST);

    // Plate format check on the fully assembled entry
    always_comb begin
        k1 = pair_kind(shreg[23:16]);
        k2 = pair_kind(shreg[15:8]);
        k3 = pair_kind(shreg[7:0]);
        n_letters = 2'((k1 == K_LETTER)) + 2'((k2 == K_LETTER)) + 2'((k3 == K_LETTER));
        plate_ok = (k1 != K_MIXED) && (k2 != K_MIXED) && (k3 != K_MIXED) &&
                   ((n_letters == 2'd1) || (n_letters == 2'd2));
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; priority Clear > CharVal > timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (char_bad)     state_nxt = ERR;
                else if (char_ok) state_nxt = COLLECT;
            end
            COLLECT: begin
                if (Clear)                           state_nxt = IDLE;
                else if (char_bad)                   state_nxt = ERR;
                else if (char_ok && Count == 3'd5)   state_nxt = CHECK;
                else if (!CharVal && expired)        state_nxt = ERR;
            end
            CHECK: begin
                if (Clear)         state_nxt = IDLE;
                else if (plate_ok) state_nxt = DONE;
                else               state_nxt = ERR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the datapath and the registered outputs
    always_comb begin
        shreg_nxt   = shreg;
        matr_nxt    = Matricula;
        matrval_nxt = MatrVal;
        erro_nxt    = Erro;
        count_nxt   = Count;
        timer_nxt   = timer;
        case (state)
            IDLE, DONE, ERR: begin
                if (char_bad) begin
                    erro_nxt    = 1'b1;
                    matrval_nxt = 1'b0;
                    count_nxt   = 3'd0;
                end else if (char_ok) begin
                    shreg_nxt   = {Char, 20'h0};
                    count_nxt   = 3'd1;
                    matrval_nxt = 1'b0;
                    erro_nxt    = 1'b0;
                    timer_nxt   = '0;
                end
            end
            COLLECT: begin
                if (Clear) begin
                    shreg_nxt = '0;
                    count_nxt = 3'd0;
                    timer_nxt = '0;
                end else if (char_bad) begin
                    erro_nxt    = 1'b1;
                    matrval_nxt = 1'b0;
                    count_nxt   = 3'd0;
                    timer_nxt   = '0;
                end else if (char_ok) begin
                    for (int i = 0; i < 6; i++) begin
                        if (Count == 3'(i)) shreg_nxt[23-4*i -: 4] = Char;
                    end
                    count_nxt = Count + 3'd1;
                    timer_nxt = '0;
                end else if (expired) begin
                    erro_nxt    = 1'b1;
                    matrval_nxt = 1'b0;
                    count_nxt   = 3'd0;
                    timer_nxt   = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            CHECK: begin
                count_nxt = 3'd0;
                if (Clear) begin
                    shreg_nxt = '0;
                end else if (plate_ok) begin
                    matr_nxt    = shreg;
                    matrval_nxt = 1'b1;
                    erro_nxt    = 1'b0;
                end else begin
                    erro_nxt    = 1'b1;
                    matrval_nxt = 1'b0;
                end
            end
            default: begin
                count_nxt = 3'd0;
                timer_nxt = '0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shreg     <= '0;
            Matricula <= '0;
            MatrVal   <= 1'b0;
            Erro      <= 1'b0;
            Count     <= 3'd0;
            timer     <= '0;
        end else begin
            shreg     <= shreg_nxt;
            Matricula <= matr_nxt;
            MatrVal   <= matrval_nxt;
            Erro      <= erro_nxt;
            Count     <= count_nxt;
            timer     <= timer_nxt;
        end
    end

endmodule

// File: tb/tb_leitor_matricula.sv
// Directed self-checking bench for leitor_matricula (TIMEOUT = 8).
module tb_leitor_matricula;

    logic        CLK;
    logic        RST_N;
    logic [3:0]  Char;
    logic        CharVal;
    logic        Clear;
    logic [23:0] Matricula;
    logic        MatrVal;
    logic        Erro;
    logic [2:0]  Count;

    int checks = 0;
    int errors = 0;

    leitor_matricula #(.TIMEOUT(8)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .Char      (Char),
        .CharVal   (CharVal),
        .Clear     (Clear),
        .Matricula (Matricula),
        .MatrVal   (MatrVal),
        .Erro      (Erro),
        .Count     (Count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One-cycle strobe; returns at the falling edge after the capturing edge
    task automatic send(input logic [3:0] c);
        @(negedge CLK);
        Char    = c;
        CharVal = 1'b1;
        @(negedge CLK);
        CharVal = 1'b0;
    endtask

    task automatic send6(input logic [23:0] p);
        for (int i = 5; i >= 0; i--) begin
            logic [23:0] v;
            v = p >> (4 * i);
            send(v[3:0]);
        end
    endtask

    task automatic outs(input string tag, input logic [23:0] m, input logic mv,
                        input logic er, input logic [2:0] cnt);
        check({tag, ".matr"}, 32'(Matricula), 32'(m));
        check({tag, ".mval"}, 32'(MatrVal), 32'(mv));
        check({tag, ".erro"}, 32'(Erro), 32'(er));
        check({tag, ".cnt"}, 32'(Count), 32'(cnt));
    endtask

    initial begin
        RST_N   = 1'b0;
        Char    = 4'h0;
        CharVal = 1'b0;
        Clear   = 1'b0;
        repeat (2) @(negedge CLK);
        outs("reset", 24'h0, 1'b0, 1'b0, 3'd0);
        RST_N = 1'b1;

        // Accepted plate AA-00-00 style
        send(4'hA); send(4'hB); send(4'h1); send(4'h2);
        check("acc.cnt4", 32'(Count), 32'd4);
        send(4'h3); send(4'h4);
        check("acc.cnt6", 32'(Count), 32'd6);
        @(negedge CLK);
        outs("acc", 24'hAB1234, 1'b1, 1'b0, 3'd0);
        repeat (3) @(negedge CLK);
        outs("acc.hold", 24'hAB1234, 1'b1, 1'b0, 3'd0);

        // All digits: rejected, plate retained
        send(4'h1);
        outs("dig.start", 24'hAB1234, 1'b0, 1'b0, 3'd1);
        send(4'h2); send(4'h3); send(4'h4); send(4'h5); send(4'h6);
        @(negedge CLK);
        outs("dig", 24'hAB1234, 1'b0, 1'b1, 3'd0);

        // Mixed pair A1 rejected at CHECK
        send6(24'hA12345);
        @(negedge CLK);
        outs("mixed", 24'hAB1234, 1'b0, 1'b1, 3'd0);

        // Illegal character as third char
        send(4'h1);
        check("ill.erro_clr", 32'(Erro), 32'd0);
        send(4'h2); send(4'hF);
        outs("ill", 24'hAB1234, 1'b0, 1'b1, 3'd0);

        // Timeout after 8 idle cycles
        send(4'h1); send(4'h2); send(4'h3);
        repeat (7) @(negedge CLK);
        outs("to.pre", 24'hAB1234, 1'b0, 1'b0, 3'd3);
        @(negedge CLK);
        outs("to", 24'hAB1234, 1'b0, 1'b1, 3'd0);

        // Char coincident with expiry wins
        send(4'h1); send(4'h2); send(4'h3);
        repeat (6) @(negedge CLK);
        send(4'h4);
        outs("coin", 24'hAB1234, 1'b0, 1'b0, 3'd4);
        send(4'hC); send(4'hD);
        @(negedge CLK);
        outs("coin.acc", 24'h1234CD, 1'b1, 1'b0, 3'd0);

        // Clear together with CharVal at Count=4
        send(4'hA); send(4'hA); send(4'h1); send(4'h2);
        @(negedge CLK);
        Char = 4'h3; CharVal = 1'b1; Clear = 1'b1;
        @(negedge CLK);
        CharVal = 1'b0; Clear = 1'b0;
        outs("clr", 24'h1234CD, 1'b0, 1'b0, 3'd0);
        send6(24'h12BC34);
        // Strobe during CHECK must be ignored
        Char = 4'hF; CharVal = 1'b1;
        @(negedge CLK);
        CharVal = 1'b0;
        outs("clr.acc", 24'h12BC34, 1'b1, 1'b0, 3'd0);

        // Asynchronous reset mid-entry at Count=5
        send(4'h9); send(4'h8); send(4'hE); send(4'hE); send(4'h7);
        check("rst.cnt5", 32'(Count), 32'd5);
        #2 RST_N = 1'b0;
        #1 outs("rst", 24'h0, 1'b0, 1'b0, 3'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        send6(24'h5678DE);
        @(negedge CLK);
        outs("rst.acc", 24'h5678DE, 1'b1, 1'b0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
